// File: rtl/accum_pkg.sv
// Shared types and decode helpers for the accumulator core.
// Honours ACCUM_CORE_MULDIV_EN: without it MUL/DIV/MOD skip the operand read.
package accum_pkg;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_ADC   = 4'h3,
        OP_SUB   = 4'h4,
        OP_SBB   = 4'h5,
        OP_NEG   = 4'h6,
        OP_INC   = 4'h7,
        OP_DEC   = 4'h8,
        OP_MUL   = 4'h9,
        OP_DIV   = 4'hA,
        OP_AND   = 4'hB,
        OP_OR    = 4'hC,
        OP_XOR   = 4'hD,
        OP_MOD   = 4'hE,
        OP_JMP   = 4'hF
    } opcodeT;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_EXEC   = 3'd5
    } stateT;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    function automatic logic needs_mem_rd(input opcodeT op);
        case (op)
            OP_LOAD, OP_ADD, OP_ADC, OP_SUB, OP_SBB,
            OP_AND, OP_OR, OP_XOR: return 1'b1;
`ifdef ACCUM_CORE_MULDIV_EN
            OP_MUL, OP_DIV, OP_MOD: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU for accum_core; flagsWe marks which flag bits the op writes.
// MUL/DIV/MOD hardware exists only when ACCUM_CORE_MULDIV_EN is defined.
module accum_alu
    import accum_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] m,
    input  logic              cIn,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] resultHi,
    output logic              hiWe,
    output logic [3:0]        flagsOut,
    output logic [3:0]        flagsWe
);

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] MSB_ONLY = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sum;
    logic            carry;
    logic            ovf;
`ifdef ACCUM_CORE_MULDIV_EN
    logic [2*DATA_W-1:0] prod;
`endif

    always_comb begin
        result   = acc;
        resultHi = '0;
        hiWe     = 1'b0;
        sum      = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        flagsWe  = 4'b0000;
`ifdef ACCUM_CORE_MULDIV_EN
        prod     = '0;
`endif
        case (op)
            OP_LOAD: begin
                result  = m;
                flagsWe = 4'b0101;
            end
            OP_ADD, OP_ADC: begin
                sum     = {1'b0, acc} + {1'b0, m}
                        + ((op == OP_ADC) ? {{DATA_W{1'b0}}, cIn} : '0);
                result  = sum[DATA_W-1:0];
                carry   = sum[DATA_W];
                ovf     = (acc[MSB] == m[MSB]) && (result[MSB] != acc[MSB]);
                flagsWe = 4'b1111;
            end
            OP_SUB, OP_SBB: begin
                // The extra top bit of the difference is the borrow.
                sum     = {1'b0, acc} - {1'b0, m}
                        - ((op == OP_SBB) ? {{DATA_W{1'b0}}, cIn} : '0);
                result  = sum[DATA_W-1:0];
                carry   = sum[DATA_W];
                ovf     = (acc[MSB] != m[MSB]) && (result[MSB] != acc[MSB]);
                flagsWe = 4'b1111;
            end
            OP_NEG: begin
                result  = (~acc) + ONE;
                carry   = (acc != '0);
                ovf     = (acc == MSB_ONLY);
                flagsWe = 4'b1111;
            end
            OP_INC: begin
                result  = acc + ONE;
                carry   = (acc == '1);
                ovf     = (acc == ~MSB_ONLY);
                flagsWe = 4'b1111;
            end
            OP_DEC: begin
                result  = acc - ONE;
                carry   = (acc == '0);
                ovf     = (acc == MSB_ONLY);
                flagsWe = 4'b1111;
            end
            OP_AND: begin
                result  = acc & m;
                flagsWe = 4'b0101;
            end
            OP_OR: begin
                result  = acc | m;
                flagsWe = 4'b0101;
            end
            OP_XOR: begin
                result  = acc ^ m;
                flagsWe = 4'b0101;
            end
`ifdef ACCUM_CORE_MULDIV_EN
            OP_MUL: begin
                prod     = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, m};
                result   = prod[DATA_W-1:0];
                resultHi = prod[2*DATA_W-1:DATA_W];
                hiWe     = 1'b1;
                carry    = (resultHi != '0);
                ovf      = carry;
                flagsWe  = 4'b1111;
            end
            OP_DIV, OP_MOD: begin
                // A zero divisor leaves the data registers alone and only raises V.
                if (m == '0) begin
                    ovf     = 1'b1;
                    flagsWe = 4'b1000;
                end else begin
                    result   = (op == OP_DIV) ? (acc / m) : (acc % m);
                    resultHi = acc % m;
                    hiWe     = (op == OP_DIV);
                    flagsWe  = 4'b0101;
                end
            end
`else
            OP_MUL, OP_DIV, OP_MOD: begin
                ovf     = 1'b1;
                flagsWe = 4'b1000;
            end
`endif
            default: ;
        endcase
        flagsOut = {ovf, result[MSB], carry, (result == '0)};
    end

endmodule

// File: rtl/accum_core.sv
// Accumulator processor core: two-word fetch over a req/ack port, then execute.
// Define ACCUM_CORE_MULDIV_EN to build the multiplier and divider.
module accum_core
    import accum_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] acc_hi,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              instr_done
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP1   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP2   = ADDR_W'(2);

    stateT             state;
    stateT             nextState;
    opcodeT            opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] mOperand;

    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] aluResultHi;
    logic              aluHiWe;
    logic [3:0]        aluFlags;
    logic [3:0]        aluFlagsWe;

    accum_alu #(.DATA_W(DATA_W)) uAlu (
        .op      (opcode),
        .acc     (acc),
        .m       (mOperand),
        .cIn     (flags[FLAG_C]),
        .result  (aluResult),
        .resultHi(aluResultHi),
        .hiWe    (aluHiWe),
        .flagsOut(aluFlags),
        .flagsWe (aluFlagsWe)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (run) nextState = S_FETCH0;
            S_FETCH0: if (mem_ack) nextState = S_FETCH1;
            S_FETCH1: if (mem_ack) begin
                if (opcode == OP_STORE)        nextState = S_MEM_WR;
                else if (needs_mem_rd(opcode)) nextState = S_MEM_RD;
                else                           nextState = S_EXEC;
            end
            S_MEM_RD: if (mem_ack) nextState = S_EXEC;
            S_MEM_WR: if (mem_ack) nextState = S_IDLE;
            S_EXEC:   nextState = S_IDLE;
            default:  nextState = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Instruction word and operand capture; stale contents after reset are harmless.
    always_ff @(posedge clk) begin
        if (state == S_FETCH0 && mem_ack) opcode   <= opcodeT'(mem_rdata[3:0]);
        if (state == S_FETCH1 && mem_ack) operand  <= mem_rdata[ADDR_W-1:0];
        if (state == S_MEM_RD && mem_ack) mOperand <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            acc        <= '0;
            acc_hi     <= '0;
            flags      <= 4'b0000;
            pc         <= PC_INIT;
            instr_done <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                S_IDLE: if (run) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                end
                S_FETCH0: if (mem_ack) mem_addr <= pc + STEP1;
                S_FETCH1: if (mem_ack) begin
                    // mem_req stays high straight into the operand access.
                    if (opcode == OP_STORE) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= acc;
                        mem_addr  <= mem_rdata[ADDR_W-1:0];
                    end else if (needs_mem_rd(opcode)) begin
                        mem_addr  <= mem_rdata[ADDR_W-1:0];
                    end else begin
                        mem_req   <= 1'b0;
                    end
                end
                S_MEM_RD: if (mem_ack) mem_req <= 1'b0;
                S_MEM_WR: if (mem_ack) begin
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    pc         <= pc + STEP2;
                    instr_done <= 1'b1;
                end
                S_EXEC: begin
                    acc <= aluResult;
                    if (aluHiWe) acc_hi <= aluResultHi;
                    flags      <= (flags & ~aluFlagsWe) | (aluFlags & aluFlagsWe);
                    pc         <= (opcode == OP_JMP) ? operand : pc + STEP2;
                    instr_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_core.sv
// Scoreboard bench for accum_core: zero-wait run, random-wait run, reset mid-read.
// Expected results follow ACCUM_CORE_MULDIV_EN as the RTL is built.
module tb_accum_core;

`ifdef ACCUM_CORE_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int NPROG = 26;

    logic       clk = 1'b0;
    logic       rst, run;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] acc, acc_hi, pc;
    logic [3:0] flags;
    logic       busy, instr_done;

    accum_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .acc(acc), .acc_hi(acc_hi), .flags(flags), .pc(pc),
        .busy(busy), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] hi;
        logic [3:0] flags;
        logic [3:0] mask;
        logic [7:0] pc;
        int         cycles;
    } expT;

    expT        expQ[$];
    logic [7:0] ram [256];
    int         nTests = 0;
    int         nFail  = 0;
    int         mode   = 0;     // 0 zero-wait, 1 random waits, 2 stall on 0x42
    bit         withCycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [7:0] a, input logic [7:0] h, input logic [3:0] f,
                           input logic [3:0] mk, input logic [7:0] p, input int cyc);
        expT e;
        e.acc = a; e.hi = h; e.flags = f; e.mask = mk; e.pc = p;
        e.cycles = withCycles ? cyc : 0;
        expQ.push_back(e);
    endtask

    task automatic pushAll();
        logic [7:0] h;
        h = MD ? 8'h01 : 8'h00;
        pushExp(8'hF0, 8'h00, 4'b0100, 4'hF, 8'h02, 4);                          // LOAD
        pushExp(8'h10, 8'h00, 4'b0010, 4'hF, 8'h04, 4);                          // ADD carry
        pushExp(8'h05, 8'h00, 4'b0010, 4'hF, 8'h06, 4);                          // LOAD
        pushExp(8'hFF, 8'h00, 4'b0110, 4'hF, 8'h08, 4);                          // SUB borrow
        pushExp(8'hFE, 8'h00, 4'b0100, 4'hF, 8'h0A, 4);                          // SBB
        pushExp(8'h12, 8'h00, 4'b0000, 4'hF, 8'h0C, 4);                          // LOAD
        pushExp(MD ? 8'h20 : 8'h12, h, MD ? 4'b1010 : 4'b1000, 4'hF, 8'h0E, MD ? 4 : 3); // MUL
        pushExp(8'h07, h, MD ? 4'b1010 : 4'b1000, 4'hF, 8'h10, 4);               // LOAD
        pushExp(MD ? 8'h03 : 8'h07, h, MD ? 4'b0000 : 4'b1000, MD ? 4'b0101 : 4'hF, 8'h12, MD ? 4 : 3); // DIV
        pushExp(MD ? 8'h03 : 8'h07, h, 4'b1000, MD ? 4'b1000 : 4'hF, 8'h14, MD ? 4 : 3); // DIV by 0
        pushExp(MD ? 8'hFD : 8'hF9, h, 4'b0110, 4'hF, 8'h16, 3);                 // NEG
        pushExp(MD ? 8'hFE : 8'hFA, h, 4'b0100, 4'hF, 8'h18, 3);                 // INC
        pushExp(MD ? 8'hFE : 8'hFA, h, 4'b0100, 4'hF, 8'h1A, 3);                 // STORE
        pushExp(8'h7F, h, 4'b0000, 4'hF, 8'h1C, 4);                              // LOAD
        pushExp(8'h80, h, 4'b1100, 4'hF, 8'h1E, 3);                              // INC overflow
        pushExp(8'h7F, h, 4'b1000, 4'hF, 8'h20, 3);                              // DEC overflow
        pushExp(8'h00, h, 4'b1001, 4'hF, 8'h22, 4);                              // XOR zero
        pushExp(8'hFF, h, 4'b0110, 4'hF, 8'h24, 3);                              // DEC wrap
        pushExp(8'h0F, h, 4'b0010, 4'hF, 8'h26, 4);                              // AND
        pushExp(8'hFF, h, 4'b0110, 4'hF, 8'h28, 4);                              // OR
        pushExp(8'h01, h, 4'b0010, 4'hF, 8'h2A, 4);                              // ADC
        pushExp(8'h01, h, 4'b0010, 4'hF, 8'hFE, 3);                              // JMP 0xFE
        pushExp(8'h01, h, 4'b0010, 4'hF, 8'h30, 3);                              // JMP at 0xFE
        pushExp(8'h80, h, 4'b1100, 4'hF, 8'h32, 4);                              // ADD overflow
        pushExp(MD ? 8'h02 : 8'h80, h, MD ? 4'b0000 : 4'b1100, MD ? 4'b0101 : 4'hF, 8'h34, MD ? 4 : 3); // remainder
        pushExp(MD ? 8'h00 : 8'h7E, h, MD ? 4'b0001 : 4'b1000, 4'hF, 8'h36, 4);  // SUB
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] w0, input logic [7:0] w1);
        ram[a] = w0;
        ram[a + 8'd1] = w1;
    endtask

    task automatic loadProgram();
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        put(8'h00, 8'hA0, 8'h40); put(8'h02, 8'h02, 8'h41); put(8'h04, 8'h00, 8'h42);
        put(8'h06, 8'h04, 8'h43); put(8'h08, 8'h05, 8'h44); put(8'h0A, 8'h00, 8'h45);
        put(8'h0C, 8'h09, 8'h46); put(8'h0E, 8'h00, 8'h47); put(8'h10, 8'h0A, 8'h48);
        put(8'h12, 8'h0A, 8'h49); put(8'h14, 8'h06, 8'h00); put(8'h16, 8'h07, 8'h00);
        put(8'h18, 8'h01, 8'h60); put(8'h1A, 8'h00, 8'h4A); put(8'h1C, 8'h07, 8'h00);
        put(8'h1E, 8'h08, 8'h00); put(8'h20, 8'h0D, 8'h4B); put(8'h22, 8'h08, 8'h00);
        put(8'h24, 8'h0B, 8'h4C); put(8'h26, 8'h0C, 8'h4D); put(8'h28, 8'h03, 8'h4E);
        put(8'h2A, 8'h0F, 8'hFE); put(8'hFE, 8'h0F, 8'h30); put(8'h30, 8'h02, 8'h4F);
        put(8'h32, 8'h0E, 8'h50); put(8'h34, 8'h04, 8'h51);
        put(8'h40, 8'hF0, 8'h20); put(8'h42, 8'h05, 8'h06); put(8'h44, 8'h00, 8'h12);
        put(8'h46, 8'h10, 8'h07); put(8'h48, 8'h02, 8'h00); put(8'h4A, 8'h7F, 8'h7F);
        put(8'h4C, 8'h0F, 8'hF0); put(8'h4E, 8'h01, 8'h7F); put(8'h50, 8'h03, 8'h02);
    endtask

    // Memory model: acks after 0..3 waits, checks the request held steady until ack.
    bit         pending = 1'b0;
    int         waitLeft;
    logic [7:0] capAddr, capWd;
    logic       capWe;

    always @(negedge clk) begin
        mem_rdata = 8'($urandom);
        if (!mem_req) begin
            pending = 1'b0;
            mem_ack = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            if (!pending) begin
                pending  = 1'b1;
                capAddr  = mem_addr;
                capWe    = mem_we;
                capWd    = mem_wdata;
                waitLeft = (mode == 1) ? $urandom_range(0, 3) : 0;
            end
            if (mode == 2 && mem_addr == 8'h42) begin
                mem_ack = 1'b0;
            end else if (waitLeft == 0) begin
                mem_ack = 1'b1;
                check("req_stable", {mem_addr, mem_we, mem_wdata}, {capAddr, capWe, capWd});
                mem_rdata = ram[mem_addr];
                if (mem_we) ram[mem_addr] = mem_wdata;
                pending = 1'b0;
            end else begin
                mem_ack = 1'b0;
                waitLeft--;
            end
        end
    end

    // Scoreboard monitor: one expectation per retired instruction.
    int busyCnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            busyCnt = 0;
        end else begin
            if (busy) busyCnt++;
            if (instr_done) begin
                if (expQ.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL unexpected_retire: pc 0x%0h, no expectation queued", pc);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    check("acc", acc, e.acc);
                    check("acc_hi", acc_hi, e.hi);
                    check("flags", flags & e.mask, e.flags & e.mask);
                    check("pc", pc, e.pc);
                    if (e.cycles != 0) check("latency", busyCnt, e.cycles);
                end
                busyCnt = 0;
            end
        end
    end

    task automatic resetCycles();
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic runPass(input int m, input bit cyc);
        int retired;
        withCycles = cyc;
        mode = m;
        loadProgram();
        pushAll();
        retired = 0;
        run = 1'b1;
        for (int c = 0; c < 3000 && retired < NPROG; c++) begin
            @(negedge clk);
            if (instr_done) retired++;
            if (retired == NPROG) run = 1'b0;
        end
        run = 1'b0;
        check("retired_count", retired, NPROG);
        repeat (4) @(negedge clk);
        check("idle_after_run", busy, 1'b0);
        check("queue_drained", expQ.size(), 0);
        check("store_data", ram[8'h60], MD ? 8'hFE : 8'hFA);
        expQ.delete();
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        mem_ack = 1'b0;
        loadProgram();
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_acc", {acc, acc_hi}, 16'h0000);
        check("rst_flags", flags, 4'h0);
        check("rst_pc", pc, 8'h00);
        check("rst_busy", {busy, instr_done}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        runPass(0, 1'b1);
        resetCycles();
        runPass(1, 1'b0);
        resetCycles();

        // Reset while the third instruction's operand read is stalled.
        withCycles = 1'b1;
        mode = 2;
        loadProgram();
        pushExp(8'hF0, 8'h00, 4'b0100, 4'hF, 8'h02, 4);
        pushExp(8'h10, 8'h00, 4'b0010, 4'hF, 8'h04, 4);
        run = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (mem_req && !mem_we && mem_addr == 8'h42) seen = 1'b1;
            end
            check("stall_reached", seen, 1'b1);
        end
        repeat (2) @(negedge clk);
        check("pre_rst_acc", acc, 8'h10);
        check("pre_rst_req", mem_req, 1'b1);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_acc", acc, 8'h00);
        check("midrst_pc", pc, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_flags", flags, 4'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("stay_idle", {busy, mem_req}, 2'b00);
        check("reset_queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
